// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier front end: feeder FSM states and the
// default engine bus width.
package mul_pkg;

    // Default operand/product width of the repeated-addition engine.
    localparam int MUL_W = 16;

    // Feeder sequencing states, in job order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        RUN,
        RESULT,
        RESTART
    } feeder_state_t;

endpackage

// File: rtl/op_fifo.sv
// Operand-pair FIFO: DEPTH entries of 2*W bits (A in the upper half, B in the
// lower half), show-ahead read port, synchronous active-high reset.
// Pointers carry one extra bit so full and empty can be told apart.
module op_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_wr_en,
    input  logic [2*W-1:0] i_wr_data,
    input  logic           i_rd_en,
    output logic [2*W-1:0] o_rd_data,
    output logic           o_full,
    output logic           o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [2*W-1:0] r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_wr;
    logic           w_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; a write and a read in the same cycle both advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; empty pointers make stale entries unreadable.
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// Operand sequencer in front of the repeated-addition multiplier engine.
// Buffers operand pairs, drives the START / A / B bus sequence, waits for done,
// returns the product and restarts the engine for the next job.
// Optional build macro: MUL_FEEDER_ZERO_BYPASS_EN -- a pair with a zero operand
// skips the engine and yields 0 directly (restart still issued).
module mul_operand_feeder
    import mul_pkg::*;
#(
    parameter int W     = MUL_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_op_valid,
    output logic         o_op_ready,
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_eng_data,
    output logic         o_eng_start,
    output logic         o_eng_rst,
    input  logic         i_eng_done,
    input  logic [W-1:0] i_eng_prod,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [W-1:0] o_res_data
);

    feeder_state_t  r_state;
    feeder_state_t  w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_eng_data;
    logic           r_eng_start;
    logic           r_eng_rst;
    logic           r_res_valid;
    logic [W-1:0]   r_res_data;
    logic [W-1:0]   w_eng_data_nxt;

    logic           w_full;
    logic           w_empty;
    logic [2*W-1:0] w_head;
    logic           w_push;
    logic           w_idle;
    logic           w_take_direct;
    logic           w_start_job;
    logic [W-1:0]   w_job_a;
    logic [W-1:0]   w_job_b;
    logic [W-1:0]   w_cur_a;
    logic [W-1:0]   w_cur_b;

    // Ready depends only on occupancy, held low while reset is asserted.
    assign o_op_ready = !w_full && !rst;
    assign w_push     = i_op_valid && o_op_ready;
    assign w_idle     = (r_state == IDLE);

    // An arriving pair meeting an empty FIFO and an idle FSM starts at once,
    // so it is taken straight from the inputs instead of being stored.
    assign w_take_direct = w_idle && w_empty && w_push;
    assign w_start_job   = w_idle && (!w_empty || w_push);
    assign w_job_a       = w_empty ? i_op_a : w_head[2*W-1:W];
    assign w_job_b       = w_empty ? i_op_b : w_head[W-1:0];

    // Operands for the bus: the incoming job while leaving IDLE, else the latched job.
    assign w_cur_a = w_idle ? w_job_a : r_a;
    assign w_cur_b = w_idle ? w_job_b : r_b;

    op_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push && !w_take_direct),
        .i_wr_data ({i_op_a, i_op_b}),
        .i_rd_en   (w_idle),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

`ifdef MUL_FEEDER_ZERO_BYPASS_EN
    logic w_job_zero;
    assign w_job_zero = (w_job_a == '0) || (w_job_b == '0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic and next value of the engine data bus.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_next         = r_state;
        w_eng_data_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_start_job) begin
`ifdef MUL_FEEDER_ZERO_BYPASS_EN
                    w_next = w_job_zero ? RESULT : START;
`else
                    w_next = START;
`endif
                end
            end
            START:   w_next = LOAD_A;
            LOAD_A:  w_next = LOAD_B;
            LOAD_B:  w_next = RUN;
            RUN:     if (i_eng_done) w_next = RESULT;
            RESULT:  if (i_res_ready) w_next = RESTART;
            RESTART: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        case (w_next)
            START, LOAD_A: w_eng_data_nxt = w_cur_a;
            LOAD_B, RUN:   w_eng_data_nxt = w_cur_b;
            default:       w_eng_data_nxt = '0;
        endcase
    end

    // Job latch and registered outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_eng_data  <= '0;
            r_eng_start <= 1'b0;
            r_eng_rst   <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (w_start_job) begin
                r_a <= w_job_a;
                r_b <= w_job_b;
            end
            r_eng_data  <= w_eng_data_nxt;
            r_eng_start <= (w_next == START);
            r_eng_rst   <= (w_next == RESTART);
            r_res_valid <= (w_next == RESULT);
            if (r_state == RUN && i_eng_done) r_res_data <= i_eng_prod;
            else if (w_idle && w_next == RESULT) r_res_data <= '0;
        end
    end

    assign o_eng_data  = r_eng_data;
    assign o_eng_start = r_eng_start;
    assign o_eng_rst   = r_eng_rst;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed bench for mul_operand_feeder with a small behavioural engine stub.
// Honours MUL_FEEDER_ZERO_BYPASS_EN for the zero-operand case.
module tb_mul_operand_feeder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_op_valid = 1'b0;
    logic         o_op_ready;
    logic [W-1:0] i_op_a = '0;
    logic [W-1:0] i_op_b = '0;
    logic [W-1:0] o_eng_data;
    logic         o_eng_start;
    logic         o_eng_rst;
    logic         i_eng_done = 1'b0;
    logic [W-1:0] i_eng_prod = '0;
    logic         o_res_valid;
    logic         i_res_ready = 1'b0;
    logic [W-1:0] o_res_data;

    int n_checks = 0;
    int n_errors = 0;

    mul_operand_feeder #(.W(W), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_op_valid  (i_op_valid),
        .o_op_ready  (o_op_ready),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .o_eng_data  (o_eng_data),
        .o_eng_start (o_eng_start),
        .o_eng_rst   (o_eng_rst),
        .i_eng_done  (i_eng_done),
        .i_eng_prod  (i_eng_prod),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data)
    );

    always #5 clk = ~clk;

    // Engine stub: A taken in the start cycle, B two cycles later, done after
    // a short run, held until the engine is restarted.
    logic [2:0]   stub_ph = '0;
    logic [W-1:0] stub_a = '0;
    logic [W-1:0] stub_b = '0;
    int           stub_starts = 0;

    always @(posedge clk) begin
        if (o_eng_start) stub_starts <= stub_starts + 1;
        if (o_eng_rst === 1'b1) begin
            stub_ph    <= '0;
            i_eng_done <= 1'b0;
            i_eng_prod <= '0;
        end else if (o_eng_start) begin
            stub_ph <= 3'd1;
            stub_a  <= o_eng_data;
        end else if (stub_ph == 3'd1) begin
            stub_ph <= 3'd2;
        end else if (stub_ph == 3'd2) begin
            stub_b  <= o_eng_data;
            stub_ph <= 3'd3;
        end else if (stub_ph >= 3'd3 && stub_ph < 3'd6) begin
            stub_ph <= stub_ph + 3'd1;
        end else if (stub_ph == 3'd6) begin
            i_eng_done <= 1'b1;
            i_eng_prod <= stub_a * stub_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair and hold it until accepted (bounded).
    task automatic push_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        i_op_valid = 1'b1;
        i_op_a     = a;
        i_op_b     = b;
        while (!o_op_ready && n < 300) begin
            tick();
            n++;
        end
        check({tag, " accepted"}, {31'd0, o_op_ready}, 32'd1);
        tick();
        i_op_valid = 1'b0;
    endtask

    // Wait for a result (bounded), compare it, then accept it.
    task automatic get_result(input string tag, input logic [W-1:0] exp);
        int n = 0;
        while (!o_res_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, " valid"}, {31'd0, o_res_valid}, 32'd1);
        check(tag, {16'd0, o_res_data}, {16'd0, exp});
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        logic seen;

        // Reset cycle and the cycle after it.
        rst = 1'b1;
        tick();
        check("rst op_ready", {31'd0, o_op_ready}, 32'd0);
        check("rst eng_rst", {31'd0, o_eng_rst}, 32'd1);
        check("rst eng_data", {16'd0, o_eng_data}, 32'd0);
        check("rst eng_start", {31'd0, o_eng_start}, 32'd0);
        check("rst res_valid", {31'd0, o_res_valid}, 32'd0);
        check("rst res_data", {16'd0, o_res_data}, 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst op_ready", {31'd0, o_op_ready}, 32'd1);
        check("post-rst eng_rst", {31'd0, o_eng_rst}, 32'd0);

        // Single job 17*5: START/LOAD_A/LOAD_B/RUN bus sequence.
        i_op_valid = 1'b1; i_op_a = 16'd17; i_op_b = 16'd5;
        tick();
        i_op_valid = 1'b0;
        check("t+1 start", {31'd0, o_eng_start}, 32'd1);
        check("t+1 data", {16'd0, o_eng_data}, 32'd17);
        tick();
        check("t+2 start", {31'd0, o_eng_start}, 32'd0);
        check("t+2 data", {16'd0, o_eng_data}, 32'd17);
        tick();
        check("t+3 data", {16'd0, o_eng_data}, 32'd5);
        tick();
        check("t+4 data", {16'd0, o_eng_data}, 32'd5);
        n = 0;
        while (!i_eng_done && n < 100) begin
            tick();
            n++;
        end
        check("done seen", {31'd0, i_eng_done}, 32'd1);
        check("done cycle valid", {31'd0, o_res_valid}, 32'd0);
        tick();
        check("d+1 valid", {31'd0, o_res_valid}, 32'd1);
        check("d+1 data", {16'd0, o_res_data}, 32'd85);

        // Result held for 10 cycles while two pairs fill the FIFO.
        s0 = stub_starts;
        i_op_valid = 1'b1; i_op_a = 16'd3; i_op_b = 16'd4;
        tick();
        i_op_a = 16'd7; i_op_b = 16'd2;
        check("one queued ready", {31'd0, o_op_ready}, 32'd1);
        tick();
        i_op_a = 16'hFFFF; i_op_b = 16'd2;
        check("full ready", {31'd0, o_op_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("hold valid", {31'd0, o_res_valid}, 32'd1);
            check("hold data", {16'd0, o_res_data}, 32'd85);
            check("hold full", {31'd0, o_op_ready}, 32'd0);
        end
        check("hold no start", stub_starts, s0);

        // Accept at edge r: RESTART r+1, IDLE r+2, next START r+3.
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        check("r+1 eng_rst", {31'd0, o_eng_rst}, 32'd1);
        check("r+1 valid", {31'd0, o_res_valid}, 32'd0);
        check("r+1 data held", {16'd0, o_res_data}, 32'd85);
        tick();
        check("r+2 start", {31'd0, o_eng_start}, 32'd0);
        check("r+2 eng_rst", {31'd0, o_eng_rst}, 32'd0);
        tick();
        check("r+3 start", {31'd0, o_eng_start}, 32'd1);
        check("r+3 data", {16'd0, o_eng_data}, 32'd3);
        check("r+3 ready", {31'd0, o_op_ready}, 32'd1);
        tick();
        i_op_valid = 1'b0;
        get_result("res 3*4", 16'd12);
        get_result("res 7*2", 16'd14);
        get_result("res FFFF*2", 16'hFFFE);

        // Simultaneous write and read with one entry queued.
        push_pair("p1", 16'd1, 16'd1);
        push_pair("p2", 16'd2, 16'd5);
        n = 0;
        while (!o_res_valid && n < 300) begin
            tick();
            n++;
        end
        check("sim res 1*1", {16'd0, o_res_data}, 32'd1);
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        tick();
        i_op_valid = 1'b1; i_op_a = 16'd6; i_op_b = 16'd7;
        check("sim idle ready", {31'd0, o_op_ready}, 32'd1);
        tick();
        check("sim start", {31'd0, o_eng_start}, 32'd1);
        check("sim start data", {16'd0, o_eng_data}, 32'd2);
        check("sim occupancy kept", {31'd0, o_op_ready}, 32'd1);
        i_op_a = 16'd9; i_op_b = 16'd3;
        tick();
        i_op_valid = 1'b0;
        check("sim now full", {31'd0, o_op_ready}, 32'd0);
        get_result("sim res 2*5", 16'd10);
        get_result("sim res 6*7", 16'd42);
        get_result("sim res 9*3", 16'd27);
        s0 = stub_starts;
        for (int i = 0; i < 20; i++) tick();
        check("sim no extra job", stub_starts, s0);

        // Reset during RUN with one pair queued.
        push_pair("rj1", 16'd2, 16'd3);
        push_pair("rj2", 16'd4, 16'd4);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst op_ready", {31'd0, o_op_ready}, 32'd0);
        check("midrst eng_rst", {31'd0, o_eng_rst}, 32'd1);
        check("midrst eng_data", {16'd0, o_eng_data}, 32'd0);
        check("midrst eng_start", {31'd0, o_eng_start}, 32'd0);
        check("midrst res_valid", {31'd0, o_res_valid}, 32'd0);
        check("midrst res_data", {16'd0, o_res_data}, 32'd0);
        rst = 1'b0;
        tick();
        check("after midrst ready", {31'd0, o_op_ready}, 32'd1);
        s0 = stub_starts;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_res_valid) seen = 1'b1;
        end
        check("midrst no result", {31'd0, seen}, 32'd0);
        check("midrst fifo empty", stub_starts, s0);
        push_pair("recover", 16'd5, 16'd6);
        get_result("res 5*6", 16'd30);

        // Zero operand pair.
        s0 = stub_starts;
        push_pair("zero", 16'd0, 16'd9);
        get_result("res 0*9", 16'd0);
`ifdef MUL_FEEDER_ZERO_BYPASS_EN
        check("zero starts", stub_starts - s0, 32'd0);
`else
        check("zero starts", stub_starts - s0, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_operand_feeder.md
# mul_operand_feeder

Front-end sequencer that sits directly upstream of the repeated-addition multiplier engine (datapath + controller). Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. Time-multiplexes each pair onto the engine's single `data_in` bus with the required start/A/B cycle sequence, waits for `done`, captures the product and returns it over a second valid/ready handshake. Resets the engine between jobs so back-to-back multiplications are possible.

## Interface
Parameters:
- `W`, 16, operand and product width (matches engine bus width)
- `DEPTH`, 2, operand FIFO depth in pairs; power of two, ≥2

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `op_valid` in 1: operand pair offered
- `op_ready` out 1: FIFO not full
- `op_a` in W: multiplicand (engine register A)
- `op_b` in W: multiplier/count (engine register B)
- `eng_data` out W: engine `DataIn` bus
- `eng_start` out 1: engine start
- `eng_rst` out 1: engine restart pulse (returns controller to idle, clears P)
- `eng_done` in 1: engine done
- `eng_prod` in W: engine product register P
- `res_valid` out 1: result available
- `res_ready` in 1: consumer accepts result
- `res_data` out W: product, modulo 2^W

## Operation
- FIFO write on `op_valid && op_ready`; read when the FSM leaves IDLE. Write and read in the same cycle are both honoured; occupancy is unchanged.
- FSM states:
  - IDLE: FIFO non-empty → START.
  - START (1 cycle): `eng_start`=1, `eng_data`=A → LOAD_A.
  - LOAD_A (1 cycle): `eng_data`=A → LOAD_B.
  - LOAD_B (1 cycle): `eng_data`=B → RUN.
  - RUN: `eng_data`=B held. First cycle with `eng_done`=1 captures `eng_prod` into `res_data` → RESULT.
  - RESULT: `res_valid`=1; on `res_ready` → RESTART.
  - RESTART (1 cycle): `eng_rst`=1 → IDLE.
- Pair latched into internal A/B registers on leaving IDLE; FIFO contents after that are irrelevant to the job in flight.
- `eng_data` in IDLE/RESULT/RESTART = 0. `eng_start`=0 outside START.
- `res_data` is stable while `res_valid`=1, and holds its last value otherwise.
- Full FIFO: `op_ready`=0 and input is ignored. Empty FIFO: stay IDLE.
- Pointer wrap-around is modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- `rst` mid-job: FSM→IDLE, FIFO emptied, pending result dropped, and `eng_rst`=1 during that reset cycle.

## Timing
- Reset values: `op_ready`=1 (0 during the `rst` cycle itself), `eng_data`=0, `eng_start`=0, `eng_rst`=1 while `rst` is high and 0 after, `res_valid`=0, `res_data`=0.
- All outputs are registered except `op_ready`, which is combinational from occupancy only.
- Pair accepted at edge t, FIFO previously empty and FSM in IDLE: START during cycle t+1, LOAD_A t+2, LOAD_B t+3, RUN from t+4.
- `eng_done` seen in cycle d: `res_valid`=1 from d+1.
- Result accepted at edge r: RESTART in cycle r+1, IDLE r+2. Earliest next START is r+3.
- Minimum job overhead excluding engine run time: 6 cycles.

## Configuration
- `MUL_FEEDER_ZERO_BYPASS_EN` defined:
  - If A==0 or B==0 when leaving IDLE, go directly to RESULT with `res_data`=0.
  - The engine is not started.
  - RESTART is still executed.
- Undefined: every pair, including zero operands, goes through the engine.
  - B==0 relies on engine behaviour; the engine decrements and wraps through 2^W cycles before `done`.

## Structure
- Shared package `mul_pkg`: FSM state enum `feeder_state_t` (IDLE, START, LOAD_A, LOAD_B, RUN, RESULT, RESTART) and default width constant `MUL_W`=16.
- One sub-module: `op_fifo`, a parameterised synchronous FIFO with W*2-bit entries, DEPTH entries, `full`/`empty` outputs and the same clk/rst.

## Test plan
- Single job A=17, B=5 → START/LOAD_A/LOAD_B on cycles t+1..t+3 with `eng_data` sequence 17,17,5; after stub `done`, `res_data`=85 and `res_valid`=1 one cycle after `done`.
- Three pairs (3,4),(7,2),(0xFFFF,2) offered back-to-back with DEPTH=2 → `op_ready` drops after two accepted; results 12, 14, 0xFFFE, in order.
- `res_ready` held low 10 cycles → `res_valid` and `res_data` stable; no START issued until RESTART completes.
- `rst` asserted during RUN → next cycle all outputs at reset values, FIFO empty, no result emitted.
- Pair (0,9) with `MUL_FEEDER_ZERO_BYPASS_EN` → `res_data`=0, `eng_start` never asserted. Without the macro → engine sequenced normally.
- Simultaneous FIFO write and read with FIFO full-minus-one → occupancy unchanged, no drop or duplicate.
